mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for a single shared memory port. It sits between the instruction-fetch stage, the data (MEM) stage and one unified backing memory. It serialises their transactions over one request/acknowledge interface and returns read data and completion pulses to each side. Data accesses have priority, and a bounded-streak counter guarantees fetch forward progress. A fetch flush suppresses completion of a fetch that is in flight or about to be granted.

## Interface
Parameters:
- ADDR_W, 32, address width (both requesters and memory)
- DATA_W, 32, data width
- SEL_W, 4, byte-select width (DATA_W/8)
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; legal range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_done or i_flush
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  pipeline flush (branch/jump); cancels pending fetch completion
- i_rdata  out  DATA_W  fetched word, valid while i_done=1
- i_done  out  1  one-cycle fetch completion pulse
- i_stall  out  1  i_req & ~i_done (combinational)
- d_req  in  1  data request; held with fields stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_sel  in  SEL_W  byte selects
- d_rdata  out  DATA_W  load data, valid while d_done=1
- d_done  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_done (combinational)
- m_req  out  1  memory request, held until m_ack
- m_we, m_addr, m_wdata, m_sel  out  1/ADDR_W/DATA_W/SEL_W  registered transaction fields
- m_ack  in  1  memory acknowledge, one cycle; m_rdata valid with it
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY_I / BUSY_D: m_req=1, wait for m_ack.
  - RESP: pulse done, return to IDLE.
- IDLE arbitration, evaluated each cycle in IDLE:
  - A fetch is eligible when i_req=1 and i_flush=0.
  - d_req only: grant D.
  - Eligible fetch only: grant I.
  - Both: grant I if streak == MAX_D_STREAK, otherwise grant D.
- Grant actions:
  - Latch the winner's fields into m_*; a fetch is latched with m_we=0, m_wdata=0 and m_sel all ones.
  - Go to BUSY_I or BUSY_D.
- Streak counter, width 4 bits, saturating at MAX_D_STREAK:
  - D grant with an eligible fetch waiting: streak+1.
  - Any I grant: streak cleared to 0.
  - IDLE with no eligible fetch: streak cleared to 0.
- BUSY_x:
  - m_req stays 1.
  - On m_ack: capture m_rdata into the winner's rdata register (reads only; on a write, d_rdata keeps its old value), drop m_req, go to RESP.
- RESP:
  - Assert done for the winner, unless it is a cancelled fetch.
  - Next state is IDLE; no arbitration happens in RESP.
- Flush:
  - i_flush=1 in any cycle while in BUSY_I sets a cancel flag.
  - In RESP with the flag set: i_done stays 0 and i_rdata is not updated.
  - The flag clears on entry to IDLE.
  - The memory transaction always runs to m_ack; a request is never withdrawn.
- i_flush has no effect on data transactions.

## Timing
- Reset (async): state IDLE; m_req, m_we, i_done, d_done, busy = 0; m_addr, m_wdata, m_sel, i_rdata, d_rdata = 0; streak = 0; cancel = 0.
- Reset mid-transaction drops m_req immediately; the memory must discard that transaction.
- Minimum latency, m_ack in the first BUSY cycle:
  - cycle 0: request sampled in IDLE.
  - cycle 1: m_req=1, m_ack=1.
  - cycle 2: done=1.
  - cycle 3: IDLE arbitrates again.
- Back-to-back throughput is one transaction per 3 cycles.
- Each additional memory wait cycle adds one cycle of latency.
- Requesters must deassert or change req at the latest in the cycle after done. The arbiter samples again in IDLE, the cycle after RESP.
- Simultaneous cases:
  - i_flush and i_req in IDLE: no I grant that cycle.
  - i_flush in the RESP cycle of a fetch: i_done suppressed.
- m_* fields are constant from grant until the cycle after m_ack.
- The m_ack-to-done path is fully registered.
- m_ack while IDLE or RESP is ignored.

## Test plan
- Single read: d_req, d_we=0, d_addr=0x100, m_ack in the first BUSY cycle with m_rdata=0xDEADBEEF -> m_req for 1 cycle, d_done=1 two cycles after the request, d_rdata=0xDEADBEEF.
- Write with wait states: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_sel=0x3, m_ack after 3 cycles -> m_req held 3 cycles with constant m_* fields, d_done on the following cycle, d_rdata unchanged.
- Contention, MAX_D_STREAK=4: i_req and d_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I and no request ever waits more than 5 grants.
- Flush: fetch granted, i_flush pulsed in the second BUSY_I cycle, m_ack in the third -> m_ack consumed, i_done never asserts, i_rdata unchanged, next fetch is arbitrated normally.
- Flush in IDLE: i_req=1 and i_flush=1 in the same cycle, d_req=0 -> no grant that cycle; grant I the next cycle if i_flush=0.
- Async reset asserted during BUSY_D -> m_req, busy, d_done = 0 immediately; after release, a new d_req completes normally with streak=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer that shares one memory request/ack port between the fetch and data stages.
// Data wins ties, but a bounded streak of data grants guarantees a waiting fetch is eventually served.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | arbitrate between data and eligible fetch requests
// ST_BUSY_I | fetch on the memory port, m_req held until m_ack
// ST_BUSY_D | data access on the memory port, m_req held until m_ack
// ST_RESP   | completion pulse to the winner, then back to ST_IDLE
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int SEL_W        = 4,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [SEL_W-1:0]  d_sel,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [SEL_W-1:0]  m_sel,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   logic [1:0] state;
   logic [3:0] streak;
   logic       cancel;
   logic       resp_d;
   logic       fetch_ok;
   logic       grant_d;
   logic       grant_i;

   assign fetch_ok = i_req & ~i_flush;
   assign grant_d  = (state == ST_IDLE) & d_req & ~(fetch_ok & (streak == STREAK_MAX));
   assign grant_i  = (state == ST_IDLE) & fetch_ok & ~grant_d;

   // Flush is also honoured in the response cycle itself, hence the direct i_flush term.
   assign i_done  = (state == ST_RESP) & ~resp_d & ~cancel & ~i_flush;
   assign d_done  = (state == ST_RESP) & resp_d;
   assign i_stall = i_req & ~i_done;
   assign d_stall = d_req & ~d_done;
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         streak  <= 4'd0;
         cancel  <= 1'b0;
         resp_d  <= 1'b0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_sel   <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cancel <= 1'b0;
               if (grant_d) begin
                  state   <= ST_BUSY_D;
                  resp_d  <= 1'b1;
                  m_req   <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  m_sel   <= d_sel;
               end else if (grant_i) begin
                  state   <= ST_BUSY_I;
                  resp_d  <= 1'b0;
                  m_req   <= 1'b1;
                  m_we    <= 1'b0;
                  m_addr  <= i_addr;
                  m_wdata <= '0;
                  m_sel   <= '1;
               end
               // Streak only grows while a fetch is actually being passed over.
               if (grant_d && fetch_ok) begin
                  if (streak != STREAK_MAX) begin
                     streak <= streak + 4'd1;
                  end
               end else begin
                  streak <= 4'd0;
               end
            end
            ST_BUSY_I: begin
               if (i_flush) begin
                  cancel <= 1'b1;
               end
               if (m_ack) begin
                  m_req <= 1'b0;
                  state <= ST_RESP;
                  if (!(cancel || i_flush)) begin
                     i_rdata <= m_rdata;
                  end
               end
            end
            ST_BUSY_D: begin
               if (m_ack) begin
                  m_req <= 1'b0;
                  state <= ST_RESP;
                  if (!m_we) begin
                     d_rdata <= m_rdata;
                  end
               end
            end
            ST_RESP: begin
               state  <= ST_IDLE;
               cancel <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
